// File: rtl/stoch_pkg.sv
// stoch_pkg: shared decode FSM states and accumulator width helper for the stochastic decoders
package stoch_pkg;
  typedef enum logic {IDLE, ACCUM} dec_state_e;
  // A window of 2^win_bits samples spans -2^win_bits..+2^win_bits, so it needs a sign bit plus one.
  function automatic int acc_width(input int win_bits);
    return win_bits + 2;
  endfunction
endpackage

// File: rtl/stoch_signed_decode.sv
// stoch_signed_decode: one signed stochastic element, accumulating (p - m) per enabled cycle
// Ports: clk_i/rst_i clock and async active-high reset; clr_i zeroes the accumulator;
//        en_i adds this cycle's delta; p_i/m_i stream bits; sum_o = accumulator plus this cycle's delta
module stoch_signed_decode #(
  parameter int WIDTH = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    p_i,
  input  logic                    m_i,
  output logic signed [WIDTH-1:0] sum_o
);
  logic signed [WIDTH-1:0] acc_q, acc_d, delta;
  always_comb begin
    delta = (p_i & ~m_i) ? WIDTH'(1) : (m_i & ~p_i) ? {WIDTH{1'b1}} : '0;
    sum_o = acc_q + delta;
    acc_d = clr_i ? '0 : en_i ? sum_o : acc_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/stoch_signed_decode_mat.sv
// stoch_signed_decode_mat: decodes a matrix of signed stochastic streams into windowed signed counts
// Ports: CLK/RST clock and async active-high reset; start requests a window when idle;
//        A_p/A_m positive/negative streams; busy high while accumulating;
//        valid one-cycle pulse when Y updates; Y signed count per element (value = Y / 2^WIN_BITS)
module stoch_signed_decode_mat
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS = 2,
  parameter int NUM_COLS = 2,
  parameter int WIN_BITS = 8
) (
  input  logic                                             CLK,
  input  logic                                             RST,
  input  logic                                             start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                A_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                A_m,
  output logic                                             busy,
  output logic                                             valid,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_BITS+1:0]  Y
);
  localparam int AW = acc_width(WIN_BITS);
  dec_state_e state_q, state_d;
  logic [WIN_BITS-1:0] cnt_q, cnt_d;
  logic valid_q, last, clr, en;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][AW-1:0] sum, y_q, y_d;
  always_comb begin
    // The counter wraps to zero on the final sample, so it is already cleared whenever IDLE.
    last    = state_q == ACCUM && cnt_q == '1;
    clr     = state_q == IDLE && start;
    en      = state_q == ACCUM;
    state_d = state_q == IDLE ? (start ? ACCUM : IDLE) : (last ? IDLE : ACCUM);
    cnt_d   = en ? cnt_q + 1'b1 : '0;
    y_d     = last ? sum : y_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= last;
      y_q     <= y_d;
    end
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      stoch_signed_decode #(.WIDTH(AW)) u_el (
        .clk_i(CLK),
        .rst_i(RST),
        .clr_i(clr),
        .en_i (en),
        .p_i  (A_p[r][c]),
        .m_i  (A_m[r][c]),
        .sum_o(sum[r][c])
      );
    end
  end
  assign busy  = state_q == ACCUM;
  assign valid = valid_q;
  assign Y     = y_q;
endmodule

// File: tb/tb_stoch_signed_decode_mat.sv
// tb_stoch_signed_decode_mat: directed scoreboard bench for the 2x2, 16-sample decoder
module tb_stoch_signed_decode_mat;
  typedef logic [1:0][1:0][5:0] ymat_t;
  logic CLK, RST, start, busy, valid;
  logic [1:0][1:0] A_p, A_m;
  ymat_t Y, last_y;
  ymat_t sb[$];
  int n_chk, n_fail, cyc, vcyc_last;

  stoch_signed_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WIN_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .A_p(A_p), .A_m(A_m),
    .busy(busy), .valid(valid), .Y(Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: all p, 1: all m, 2: p and m, 3: per-element patterns, 4: random
  task automatic drive(input int mode, input int i);
    A_p = '0;
    A_m = '0;
    case (mode)
      0: A_p = '1;
      1: A_m = '1;
      2: begin A_p = '1; A_m = '1; end
      3: begin
        A_p[0][0] = (i % 2 == 0);
        A_m[0][1] = (i % 4 == 3);
        A_p[1][0] = (i < 12);
        A_m[1][0] = (i >= 12);
      end
      default: begin A_p = 4'($urandom); A_m = 4'($urandom); end
    endcase
  endtask

  // Caller is at a negedge; returns at the negedge where valid should be high.
  task automatic window(input int mode, input bit hold, input bit chk_period);
    int acc[2][2];
    ymat_t e;
    acc = '{'{0, 0}, '{0, 0}};
    start = 1'b1;
    @(negedge CLK);
    start = hold;
    for (int i = 0; i < 16; i++) begin
      chk("busy_high", 32'(busy), 32'd1);
      chk("valid_low", 32'(valid), 32'd0);
      chk("y_hold", 32'(Y), 32'(last_y));
      drive(mode, i);
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          acc[r][c] += int'(A_p[r][c]) - int'(A_m[r][c]);
      @(negedge CLK);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        e[r][c] = 6'(acc[r][c]);
    sb.push_back(e);
    chk("busy_done", 32'(busy), 32'd0);
    chk("valid_pulse", 32'(valid), 32'd1);
    e = sb.pop_front();
    chk("y_result", 32'(Y), 32'(e));
    last_y = e;
    if (chk_period) chk("valid_period", 32'(cyc - vcyc_last), 32'd17);
    vcyc_last = cyc;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; vcyc_last = 0;
    RST = 1'b1; start = 1'b0; A_p = '0; A_m = '0; last_y = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_y", 32'(Y), 32'd0);
    RST = 1'b0;
    window(0, 1'b0, 1'b0);
    chk("y_plus16", 32'(Y), 32'(24'h410410));
    window(3, 1'b0, 1'b0);
    chk("y_patterns", 32'(Y), 32'({6'd0, 6'd8, 6'h3c, 6'd8}));
    // abort a window of all-p samples after 7 samples
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    A_p = '1; A_m = '0;
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_y", 32'(Y), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    last_y = '0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(valid), 32'd0);
    window(1, 1'b0, 1'b0);
    chk("y_minus16", 32'(Y), 32'(24'hc30c30));
    // start held high across three back-to-back windows
    window(1, 1'b1, 1'b0);
    window(2, 1'b1, 1'b1);
    chk("y_zero", 32'(Y), 32'd0);
    window(0, 1'b1, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(4, i);
      @(negedge CLK);
      chk("hold_y", 32'(Y), 32'(24'h410410));
      chk("hold_valid", 32'(valid), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stoch_signed_decode_mat.md
Name: stoch_signed_decode_mat

Overview:
- Converts a NUM_ROWS x NUM_COLS matrix of signed stochastic bitstreams back to binary. Each element arrives as a positive (_p) and a negative (_m) stream.
- Sits at the output end of stochastic datapaths such as the signed add/sub/mul matrix blocks, so host or fixed-point logic can read results.
- Each element accumulates (p - m) over a fixed window of 2^WIN_BITS cycles and publishes a signed count with a one-cycle valid pulse.

Parameters:
- NUM_ROWS, 2, matrix row count.
- NUM_COLS, 2, matrix column count.
- WIN_BITS, 8, log2 of window length; window = 2^WIN_BITS sampled cycles.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  request a decode window; honoured only when idle.
- A_p  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  positive-polarity bitstreams.
- A_m  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  negative-polarity bitstreams.
- busy  output  1  high while a window is being accumulated.
- valid  output  1  one-cycle pulse when Y is updated.
- Y  output  [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_BITS+1:0]  signed two's-complement count per element. Range -2^WIN_BITS..+2^WIN_BITS; real value = Y / 2^WIN_BITS.

Behaviour:
- Reset (async, RST=1): state=IDLE, cycle counter=0, all accumulators=0, Y=0, valid=0, busy=0. The effect is immediate, not clock-gated.
- FSM states: IDLE, ACCUM.
- IDLE -> ACCUM on an edge where start=1; at that edge counter<=0 and all accumulators<=0. busy=1 from this edge on.
- In IDLE, A_p/A_m are ignored.
- ACCUM sampling: each edge in ACCUM samples A_p/A_m. Per element, delta = +1 if p&~m, -1 if m&~p, 0 if p==m; acc <= acc + delta. Counter increments by 1.
- The final sample is taken at the edge where counter == 2^WIN_BITS-1. At that same edge:
  - Y <= acc + delta for every element.
  - valid <= 1, busy <= 0, state <= IDLE.
  - Exactly 2^WIN_BITS samples are taken per window.
- Latency: start sampled at edge k -> samples at edges k+1..k+2^WIN_BITS -> valid high in the cycle following edge k+2^WIN_BITS.
- valid is high for exactly one cycle; it deasserts at the next edge.
- Y holds its last value until the next valid; it is never zeroed except by RST.
- start while in ACCUM is ignored, with no restart and no queuing.
- start during the valid cycle is accepted, because state is already IDLE. With start held high, valid repeats every 2^WIN_BITS+1 cycles.
- The accumulator needs WIN_BITS+2 bits and cannot overflow: |acc| <= 2^WIN_BITS.
- RST mid-window aborts the window. No valid is produced, and pre-reset samples never contribute to a later result.

Decomposition:
- Shared package stoch_pkg: decode FSM state enum (IDLE, ACCUM) and a localparam helper for accumulator width (WIN_BITS+2).
- Sub-module stoch_signed_decode: scalar element with signed accumulator, clear and enable inputs, and p/m bit inputs.
- The matrix top instantiates stoch_signed_decode via generate over rows/cols. The single FSM and cycle counter are shared in the top.

Test Plan:
- WIN_BITS=4, 2x2, A_p=all 1, A_m=all 0, one start pulse -> after 16 samples Y=+16 for all elements. valid is a single pulse in the cycle after edge k+16; busy high for exactly 16 cycles.
- A_p=0, A_m=all 1 -> Y=-16 for all; then A_p=A_m=all 1 -> Y=0 for all.
- Per-element patterns over 16 cycles:
  - [0][0] p on alternate cycles -> Y=+8.
  - [0][1] m every 4th cycle -> Y=-4.
  - [1][0] p 12 cycles and m 4 cycles, disjoint -> Y=+8.
  - [1][1] idle -> Y=0.
- start held high for 3 windows -> valid pulses 17 cycles apart. Y changes only on valid; start pulses during ACCUM cause no restart.
- RST asserted at sample 7 with A_p=all 1 -> Y=0, busy=0, valid=0 immediately. A new window with A_m=all 1 then yields Y=-16, with no residue from before reset.
- Hold check: after a result of +16, drive random streams with start=0 for 40 cycles -> Y stays +16 and valid stays 0.
